recip_div_ctrl: RTL and testbench
=================================

RECIP_DIV_CTRL -- requirements
Module: recip_div_ctrl

Interface
REQ-001 The block SHALL have parameter DIVIDEND_WIDTH, default 16, giving the dividend, quotient and remainder width.
REQ-002 The block SHALL have parameter DIVISOR_WIDTH, default 5, giving the divisor width (values 0..31).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid_0 / in_valid_1  input  1 each  requester 0/1 holds a valid division request.
REQ-006 in_ready_0 / in_ready_1  output  1 each  request accepted when in_valid_x && in_ready_x at a clock edge.
REQ-007 dividend_0 / dividend_1  input  DIVIDEND_WIDTH each  unsigned dividend per requester.
REQ-008 divisor_0 / divisor_1  input  DIVISOR_WIDTH each  unsigned divisor per requester.
REQ-009 out_valid  output  1  result held valid.
REQ-010 out_ready  input  1  consumer accepts the result when out_valid && out_ready.
REQ-011 out_id  output  1  index of the requester that owns the result.
REQ-012 quotient / remainder  output  DIVIDEND_WIDTH each  unsigned result.
REQ-013 div_err  output  1  result was produced for divisor 0.

Function
REQ-014 FSM states: IDLE, LOOK, MUL, FIX, RESP; one request in flight at a time.
REQ-015 In IDLE, in_ready SHALL be asserted only to the granted requester; all other in_ready outputs are 0.
REQ-016 Arbitration is round-robin: if both in_valid are high, grant the requester not granted last; if one is high, grant it.
REQ-017 Last-grant pointer updates only on an accept.
REQ-018 On accept: latch dividend, divisor and id; go IDLE->LOOK.
REQ-019 LOOK: register reciprocal inv (17 bits, MSB=1) and shift s for the latched divisor.
- inv = ceil(2^s/d)
- s = 16 + ceil(log2 d)
- d=1 gives inv=65536, s=16
- constant table inside the block
REQ-020 MUL: q = floor(dividend*inv / 2^s), full-width product of DIVIDEND_WIDTH+17 bits with no truncation before the shift; r = dividend - q*d.
REQ-021 FIX: if r >= d, then q = q+1 and r = r-d (one correction step); otherwise unchanged.
REQ-022 RESP: out_valid=1; quotient, remainder, out_id and div_err stable until handshake; on out_valid && out_ready go RESP->IDLE.
REQ-023 Latency: out_valid rises exactly 4 cycles after the accept edge (LOOK, MUL, FIX, then RESP visible).
REQ-024 A new request SHALL NOT be accepted in the RESP handshake cycle; the earliest next accept is the cycle after returning to IDLE.
REQ-025 Divisor 0: LOOK goes directly to RESP with div_err=1, quotient = all ones and remainder = dividend (latency 2 cycles).
REQ-026 Inputs changing after accept SHALL NOT affect the in-flight result.
REQ-027 Outputs when not in RESP: out_valid=0; quotient, remainder, out_id and div_err hold their last values.

Reset
REQ-028 rst SHALL immediately force:
- state=IDLE
- out_valid=0
- in_ready_0=in_ready_1=0 while rst is high
- quotient=0, remainder=0, out_id=0, div_err=0
- last-grant pointer=1, so requester 0 wins first
REQ-029 Reset mid-operation SHALL abort the in-flight request with no result produced.

Configuration
REQ-030 Macro RECIP_DIV_FIX_EN:
- Defined: the FIX state exists per REQ-021, and latency is 4.
- Undefined: the FIX state is removed, MUL goes to RESP, q/r are output uncorrected, and latency is 3.

Verification
REQ-031 Requester 0 sends 100/7 -> out_valid at cycle 4 after accept, quotient=14, remainder=2, out_id=0, div_err=0.
REQ-032 Requester 1 sends 65535/3 -> quotient=21845, remainder=0, out_id=1.
REQ-033 Both valid together after reset, each with 50/5 -> requester 0 served first (10, r0), then requester 1; repeat and order alternates.
REQ-034 Divisor 0 with dividend 9 -> div_err=1, quotient=0xFFFF, remainder=9, 2 cycles after accept.
REQ-035 Hold out_ready=0 for 5 cycles in RESP -> outputs stable and in_ready_0=in_ready_1=0 throughout; release -> IDLE next cycle.
REQ-036 Assert rst during MUL -> out_valid stays 0; after release, a new 31/31 request gives quotient=1, remainder=0.

Source files
------------

// File: rtl/recip_div_ctrl.sv
// recip_div_ctrl: two-requester divider using a constant reciprocal table and a multiply-shift
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   in_valid_x / in_ready_x     request handshake for requester x (0/1), round-robin arbitrated
//   dividend_x / divisor_x      unsigned operands of requester x
//   out_valid / out_ready       result handshake
//   out_id                      requester that owns the result
//   quotient / remainder        unsigned result, held until the next result
//   div_err                     result was produced for divisor 0
// Macro RECIP_DIV_FIX_EN: when defined, adds a one-step correction state (latency 4, else 3).
module recip_div_ctrl #(
    parameter int DIVIDEND_WIDTH = 16,
    parameter int DIVISOR_WIDTH  = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid_0,
    input  logic                      in_valid_1,
    output logic                      in_ready_0,
    output logic                      in_ready_1,
    input  logic [DIVIDEND_WIDTH-1:0] dividend_0,
    input  logic [DIVIDEND_WIDTH-1:0] dividend_1,
    input  logic [DIVISOR_WIDTH-1:0]  divisor_0,
    input  logic [DIVISOR_WIDTH-1:0]  divisor_1,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_id,
    output logic [DIVIDEND_WIDTH-1:0] quotient,
    output logic [DIVIDEND_WIDTH-1:0] remainder,
    output logic                      div_err
);
    localparam int DW = DIVIDEND_WIDTH;
    localparam int VW = DIVISOR_WIDTH;
    localparam int PW = DW + 17;
    localparam int ND = 2 ** VW;

    typedef enum logic [2:0] {
        IDLE,
        LOOK,
        MUL,
`ifdef RECIP_DIV_FIX_EN
        FIX,
`endif
        RESP
    } state_t;

    // ceil(2^s/d) with s = 16 + ceil(log2 d); always lands in [2^16, 2^17)
    function automatic logic [16:0] inv_of(input int d);
        logic [63:0] p;
        if (d == 0) return 17'd0;
        p = 64'd1 << (16 + $clog2(d));
        return 17'((p + 64'(d) - 64'd1) / 64'(d));
    endfunction

    logic [16:0]   w_inv_tab [ND];
    logic [7:0]    w_sh_tab  [ND];

    for (genvar g = 0; g < ND; g++) begin : g_tab
        assign w_inv_tab[g] = inv_of(g);
        assign w_sh_tab[g]  = 8'(16 + $clog2(g));
    end

    state_t        r_state;
    logic          r_last;
    logic          r_id;
    logic [DW-1:0] r_dividend;
    logic [VW-1:0] r_divisor;
    logic [16:0]   r_inv;
    logic [7:0]    r_shift;
    logic          w_gnt0;
    logic          w_gnt1;
    logic [PW-1:0] w_prod;
    logic [DW-1:0] w_q;
    logic [DW-1:0] w_r;
    logic [DW-1:0] w_dz;

    // requester 0 wins a tie when requester 1 was granted last, and vice versa
    assign w_gnt0     = in_valid_0 && (!in_valid_1 || r_last);
    assign w_gnt1     = in_valid_1 && (!in_valid_0 || !r_last);
    assign in_ready_0 = !rst && (r_state == IDLE) && w_gnt0;
    assign in_ready_1 = !rst && (r_state == IDLE) && w_gnt1;

    // full-width product, no truncation before the shift
    assign w_dz   = DW'(r_divisor);
    assign w_prod = {17'd0, r_dividend} * {{DW{1'b0}}, r_inv};
    assign w_q    = DW'(w_prod >> r_shift);
    assign w_r    = r_dividend - w_q * w_dz;

`ifdef RECIP_DIV_FIX_EN
    logic [DW-1:0] r_q;
    logic [DW-1:0] r_r;
    logic          w_fix;
    assign w_fix = r_r >= w_dz;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_last     <= 1'b1;
            r_id       <= 1'b0;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_inv      <= '0;
            r_shift    <= '0;
            out_valid  <= 1'b0;
            out_id     <= 1'b0;
            quotient   <= '0;
            remainder  <= '0;
            div_err    <= 1'b0;
`ifdef RECIP_DIV_FIX_EN
            r_q        <= '0;
            r_r        <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_ready_0 || in_ready_1) begin
                        r_dividend <= in_ready_1 ? dividend_1 : dividend_0;
                        r_divisor  <= in_ready_1 ? divisor_1 : divisor_0;
                        r_id       <= in_ready_1;
                        r_last     <= in_ready_1;
                        r_state    <= LOOK;
                    end
                end
                LOOK: begin
                    r_inv   <= w_inv_tab[r_divisor];
                    r_shift <= w_sh_tab[r_divisor];
                    if (r_divisor == '0) begin
                        quotient  <= '1;
                        remainder <= r_dividend;
                        div_err   <= 1'b1;
                        out_id    <= r_id;
                        out_valid <= 1'b1;
                        r_state   <= RESP;
                    end else begin
                        r_state <= MUL;
                    end
                end
                MUL: begin
`ifdef RECIP_DIV_FIX_EN
                    r_q     <= w_q;
                    r_r     <= w_r;
                    r_state <= FIX;
`else
                    quotient  <= w_q;
                    remainder <= w_r;
                    div_err   <= 1'b0;
                    out_id    <= r_id;
                    out_valid <= 1'b1;
                    r_state   <= RESP;
`endif
                end
`ifdef RECIP_DIV_FIX_EN
                FIX: begin
                    quotient  <= w_fix ? r_q + 1'b1 : r_q;
                    remainder <= w_fix ? r_r - w_dz : r_r;
                    div_err   <= 1'b0;
                    out_id    <= r_id;
                    out_valid <= 1'b1;
                    r_state   <= RESP;
                end
`endif
                RESP: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_recip_div_ctrl.sv
// tb_recip_div_ctrl: randomized self-checking bench for recip_div_ctrl against an arithmetic model
module tb_recip_div_ctrl;
`ifdef RECIP_DIV_FIX_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic        clk;
    logic        rst;
    logic        in_valid_0;
    logic        in_valid_1;
    logic        in_ready_0;
    logic        in_ready_1;
    logic [15:0] dividend_0;
    logic [15:0] dividend_1;
    logic [4:0]  divisor_0;
    logic [4:0]  divisor_1;
    logic        out_valid;
    logic        out_ready;
    logic        out_id;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_err;

    int   n_cmp = 0;
    int   n_bad = 0;
    logic last  = 1'b1;

    recip_div_ctrl #(.DIVIDEND_WIDTH(16), .DIVISOR_WIDTH(5)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid_0 (in_valid_0),
        .in_valid_1 (in_valid_1),
        .in_ready_0 (in_ready_0),
        .in_ready_1 (in_ready_1),
        .dividend_0 (dividend_0),
        .dividend_1 (dividend_1),
        .divisor_0  (divisor_0),
        .divisor_1  (divisor_1),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_id     (out_id),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_err    (div_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_req(input logic v0, input logic v1, input logic [15:0] n0, input logic [15:0] n1,
                           input logic [4:0] d0, input logic [4:0] d1, input int hold);
        logic        g;
        logic [15:0] n;
        logic [4:0]  d;
        logic [15:0] eq;
        logic [15:0] er;
        int          cyc;
        @(negedge clk);
        in_valid_0 = v0;
        in_valid_1 = v1;
        dividend_0 = n0;
        dividend_1 = n1;
        divisor_0  = d0;
        divisor_1  = d1;
        #1;
        g = (v0 && v1) ? ~last : v1;
        chk("in_ready_0", in_ready_0, !g);
        chk("in_ready_1", in_ready_1, g);
        last = g;
        n  = g ? n1 : n0;
        d  = g ? d1 : d0;
        eq = (d == 0) ? 16'hFFFF : n / 16'(d);
        er = (d == 0) ? n : n % 16'(d);
        @(posedge clk);
        @(negedge clk);
        in_valid_0 = 1'b0;
        in_valid_1 = 1'b0;
        dividend_0 = 16'($urandom);
        dividend_1 = 16'($urandom);
        divisor_0  = 5'($urandom);
        divisor_1  = 5'($urandom);
        cyc = 1;
        while (!out_valid && cyc < 12) begin
            @(negedge clk);
            cyc++;
        end
        chk("latency", 64'(cyc), 64'((d == 0) ? 2 : LAT));
        chk("quotient", quotient, eq);
        chk("remainder", remainder, er);
        chk("out_id", out_id, g);
        chk("div_err", div_err, d == 0);
        repeat (hold) begin
            @(negedge clk);
            in_valid_0 = 1'b1;
            in_valid_1 = 1'b1;
            dividend_0 = 16'($urandom);
            divisor_0  = 5'($urandom);
            #1;
            chk("hold_valid", out_valid, 1'b1);
            chk("hold_q", quotient, eq);
            chk("hold_r", remainder, er);
            chk("hold_rdy0", in_ready_0, 1'b0);
            chk("hold_rdy1", in_ready_1, 1'b0);
        end
        @(negedge clk);
        in_valid_0 = 1'b0;
        in_valid_1 = 1'b0;
        out_ready  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_valid", out_valid, 1'b0);
        chk("post_q", quotient, eq);
        chk("post_r", remainder, er);
    endtask

    initial begin
        rst        = 1'b1;
        in_valid_0 = 1'b1;
        in_valid_1 = 1'b1;
        dividend_0 = '0;
        dividend_1 = '0;
        divisor_0  = '0;
        divisor_1  = '0;
        out_ready  = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_rdy0", in_ready_0, 1'b0);
        chk("rst_rdy1", in_ready_1, 1'b0);
        chk("rst_q", quotient, 16'h0);
        chk("rst_r", remainder, 16'h0);
        chk("rst_id", out_id, 1'b0);
        chk("rst_err", div_err, 1'b0);
        rst        = 1'b0;
        in_valid_0 = 1'b0;
        in_valid_1 = 1'b0;
        last       = 1'b1;

        run_req(1, 0, 16'd100, 16'd0, 5'd7, 5'd0, 0);
        run_req(0, 1, 16'd0, 16'd65535, 5'd0, 5'd3, 1);
        run_req(1, 0, 16'd9, 16'd0, 5'd0, 5'd0, 0);
        run_req(1, 1, 16'd1000, 16'd777, 5'd13, 5'd31, 5);

        // abort during MUL
        @(negedge clk);
        in_valid_0 = 1'b1;
        dividend_0 = 16'd1234;
        divisor_0  = 5'd7;
        #1;
        chk("abort_rdy0", in_ready_0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        in_valid_0 = 1'b0;
        @(negedge clk);
        rst        = 1'b1;
        in_valid_0 = 1'b1;
        #1;
        chk("abort_rdy_rst", in_ready_0, 1'b0);
        chk("abort_valid", out_valid, 1'b0);
        repeat (3) begin
            @(negedge clk);
            chk("abort_hold", out_valid, 1'b0);
        end
        rst        = 1'b0;
        in_valid_0 = 1'b0;
        last       = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("abort_nores", out_valid, 1'b0);
        end
        chk("abort_q", quotient, 16'h0);
        run_req(1, 0, 16'd31, 16'd0, 5'd31, 5'd0, 0);

        // tie after reset-equivalent pointer: alternating order
        rst = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        last = 1'b1;
        repeat (4) run_req(1, 1, 16'd50, 16'd50, 5'd5, 5'd5, 0);

        for (int i = 0; i < 40; i++) begin
            int   p;
            logic [4:0] da;
            logic [4:0] db;
            p  = int'($urandom_range(1, 3));
            da = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            db = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            run_req(p[0], p[1], 16'($urandom), 16'($urandom), da, db, int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
